// File: rtl/video_text_pkg.sv
// Shared definitions for the 160x45 text-mode renderer.
//   - Text geometry and pipeline latency constants.
//   - Derived field widths for column/row/glyph indexing.
//   - Text RAM word layout: [7:0] char, [11:8] fg index, [15:12] bg index.
//   - Fixed 16-colour CGA palette lookup.
package video_text_pkg;

  localparam int unsigned TEXT_COLS    = 160;
  localparam int unsigned TEXT_ROWS    = 45;
  localparam int unsigned GLYPH_W      = 8;
  localparam int unsigned GLYPH_H      = 16;
  localparam int unsigned PIPE_LATENCY = 5;

  localparam int unsigned XBIT_W = $clog2(GLYPH_W);    // pixel-in-glyph bits
  localparam int unsigned GROW_W = $clog2(GLYPH_H);    // glyph row bits
  localparam int unsigned COL_W  = $clog2(TEXT_COLS);  // 8
  localparam int unsigned ROW_W  = $clog2(TEXT_ROWS);  // 6

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] ch;
  } text_word_t;

  function automatic logic [23:0] palette_rgb(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'd0:    c = 24'h000000;
      4'd1:    c = 24'h0000AA;
      4'd2:    c = 24'h00AA00;
      4'd3:    c = 24'h00AAAA;
      4'd4:    c = 24'hAA0000;
      4'd5:    c = 24'hAA00AA;
      4'd6:    c = 24'hAA5500;
      4'd7:    c = 24'hAAAAAA;
      4'd8:    c = 24'h555555;
      4'd9:    c = 24'h5555FF;
      4'd10:   c = 24'h55FF55;
      4'd11:   c = 24'h55FFFF;
      4'd12:   c = 24'hFF5555;
      4'd13:   c = 24'hFF55FF;
      4'd14:   c = 24'hFFFF55;
      default: c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register used to align side-band fields with the
// pixel pipeline.
//   clk   : pixel clock
//   reset : synchronous, active-high; every stage loads RESET_VALUE
//   d     : input word
//   q     : d delayed by DEPTH clock edges
module video_delay_line #(
  parameter int unsigned       WIDTH       = 1,
  parameter int unsigned       DEPTH       = 1,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_text_renderer.sv
// 160x45 text-mode renderer (8x16 glyph cells) fed by the 720p timing block.
//   clk, reset            : pixel clock, synchronous active-high reset
//   x_in, y_in            : pixel column / line from the timing block
//   hsync_in, vsync_in    : input syncs; visible_in : active-area flag
//   text_addr / text_data : text RAM port (data valid 1 cycle after addr)
//   font_addr / font_data : font ROM port {char, glyph_row} (1-cycle read)
//   cursor_en/_col/_row   : blinking inverse-video cursor cell
//   rgb                   : {R,G,B} pixel, black outside the active area
//   hsync_out, vsync_out, de_out : inputs delayed to match the 5-cycle pipe
module video_text_renderer
  import video_text_pkg::*;
#(
  parameter logic        H_SYNC_ACTIVE = 1'b1,
  parameter logic        V_SYNC_ACTIVE = 1'b1,
  parameter int unsigned BLINK_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        visible_in,
  output logic [12:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [7:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  output logic [23:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  // Geometry of the current input pixel
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [GROW_W-1:0] glyph_row;
  logic [XBIT_W-1:0] xbit;
  logic [12:0]       row_ext;
  logic [12:0]       addr_next;
  logic              unused_in_bits;

  assign col       = x_in[XBIT_W +: COL_W];
  assign row       = y_in[GROW_W +: ROW_W];
  assign glyph_row = y_in[GROW_W-1:0];
  assign xbit      = x_in[XBIT_W-1:0];
  assign unused_in_bits = ^{x_in[15:XBIT_W+COL_W], y_in[15:GROW_W+ROW_W]};

  // row*160 + col as shift-add; wraps for off-screen coordinates
  assign row_ext   = 13'(row);
  assign addr_next = (row_ext << 7) + (row_ext << 5) + 13'(col);

  // Cursor blink: count rising vsync edges, toggle phase every BLINK_FRAMES
  logic       vsync_prev;
  logic [7:0] frame_cnt;
  logic       blink_phase;
  logic       vsync_rise;
  logic       cursor_hit;

  assign vsync_rise = (vsync_in == V_SYNC_ACTIVE) && (vsync_prev != V_SYNC_ACTIVE);
  // Uses the blink phase before any toggle caused by this same sample
  assign cursor_hit = cursor_en && (col == cursor_col) && (row == cursor_row) && blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev  <= ~V_SYNC_ACTIVE;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_rise) begin
        if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Stage 1: text RAM address
  always_ff @(posedge clk) begin
    if (reset) text_addr <= '0;
    else       text_addr <= addr_next;
  end

  // Side-band alignment
  logic [1:0]        sync_d;
  logic [GROW_W-1:0] grow_d;
  logic [XBIT_W-1:0] xbit_d;
  logic              cursor_d;
  logic              visible_d;
  logic [7:0]        colour_d;
  text_word_t        tw;

  assign tw = text_word_t'(text_data);

  video_delay_line #(
    .WIDTH       (2),
    .DEPTH       (PIPE_LATENCY),
    .RESET_VALUE ({~V_SYNC_ACTIVE, ~H_SYNC_ACTIVE})
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .d     ({vsync_in, hsync_in}),
    .q     (sync_d)
  );

  assign vsync_out = sync_d[1];
  assign hsync_out = sync_d[0];

  // Glyph row is needed when the text word returns (two edges later)
  video_delay_line #(
    .WIDTH (GROW_W),
    .DEPTH (2)
  ) u_grow_dly (
    .clk   (clk),
    .reset (reset),
    .d     (glyph_row),
    .q     (grow_d)
  );

  // Pixel select, cursor and visible are consumed by the final rgb register
  video_delay_line #(
    .WIDTH (XBIT_W + 2),
    .DEPTH (PIPE_LATENCY - 1)
  ) u_pix_dly (
    .clk   (clk),
    .reset (reset),
    .d     ({xbit, cursor_hit, visible_in}),
    .q     ({xbit_d, cursor_d, visible_d})
  );

  // fg/bg captured with the text word, then held one more edge for the font row
  video_delay_line #(
    .WIDTH (8),
    .DEPTH (2)
  ) u_colour_dly (
    .clk   (clk),
    .reset (reset),
    .d     ({tw.bg, tw.fg}),
    .q     (colour_d)
  );

  // Stage 3: font ROM address
  always_ff @(posedge clk) begin
    if (reset) font_addr <= '0;
    else       font_addr <= {tw.ch, grow_d};
  end

  // Stage 5: colour selection
  logic [XBIT_W-1:0] bit_idx;
  logic              pix_on;
  logic [3:0]        colour_idx;
  logic [23:0]       rgb_next;

  always_comb begin
    bit_idx    = XBIT_W'(GLYPH_W - 1) - xbit_d;
    // Cursor swaps fg/bg, equivalent to inverting the glyph bit
    pix_on     = font_data[bit_idx] ^ cursor_d;
    colour_idx = pix_on ? colour_d[3:0] : colour_d[7:4];
    rgb_next   = visible_d ? palette_rgb(colour_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb    <= '0;
      de_out <= 1'b0;
    end else begin
      rgb    <= rgb_next;
      de_out <= visible_d;
    end
  end

endmodule

// File: tb/tb_video_text_renderer.sv
// Self-checking bench for video_text_renderer: external RAM/ROM models, a
// latency-based behavioural reference, directed literal checks and
// randomized traffic.
module tb_video_text_renderer;

  localparam int BLINK = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x_in, y_in;
  logic        hsync_in, vsync_in, visible_in;
  logic [12:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        cursor_en;
  logic [7:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [23:0] rgb;
  logic        hsync_out, vsync_out, de_out;

  always #5 clk = ~clk;

  video_text_renderer #(
    .H_SYNC_ACTIVE (1'b1),
    .V_SYNC_ACTIVE (1'b1),
    .BLINK_FRAMES  (BLINK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .x_in       (x_in),
    .y_in       (y_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .visible_in (visible_in),
    .text_addr  (text_addr),
    .text_data  (text_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .de_out     (de_out)
  );

  // External synchronous memories
  logic [15:0] tram [8192];
  logic [7:0]  from [4096];

  always @(posedge clk) begin
    text_data <= tram[text_addr];
    font_data <= from[font_addr];
  end

  logic [23:0] pal [16] = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                            24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                            24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                            24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } outv_t;

  int    n_vec  = 0;
  int    n_fail = 0;
  outv_t pend[$];
  int    edges  = 0;
  logic  prev_vs = 1'b0;
  logic [11:0] fa_m1 = '0, fa_m2 = '0;
  logic  rst_m1 = 1'b1;
  int    hist = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the currently driven inputs for one edge and check all outputs
  task automatic step();
    outv_t       e, exp_o;
    logic [12:0] a;
    logic [11:0] fa_now;
    logic [15:0] w;
    logic [7:0]  g;
    logic        phase, cur, b;
    int          col, row;
    e = '0;
    if (reset) begin
      a       = '0;
      fa_now  = {tram[0][7:0], 4'h0};
      edges   = 0;
      prev_vs = 1'b0;
    end else begin
      col    = int'(x_in[10:3]);
      row    = int'(y_in[9:4]);
      a      = 13'((row * 160 + col) % 8192);
      phase  = ((edges / BLINK) % 2) == 0;
      w      = tram[a];
      fa_now = {w[7:0], y_in[3:0]};
      g      = from[fa_now];
      b      = g[7 - int'(x_in[2:0])];
      cur    = cursor_en && (col == int'(cursor_col)) && (row == int'(cursor_row)) && phase;
      e.de   = visible_in;
      e.hs   = hsync_in;
      e.vs   = vsync_in;
      e.rgb  = visible_in ? pal[(b ^ cur) ? w[11:8] : w[15:12]] : 24'h0;
      if (vsync_in && !prev_vs) edges++;
      prev_vs = vsync_in;
    end

    @(posedge clk);
    #1;

    if (reset) begin
      exp_o = '0;
      pend  = '{outv_t'(0), outv_t'(0), outv_t'(0), outv_t'(0)};
    end else begin
      pend.push_back(e);
      exp_o = pend.pop_front();
    end
    chk("text_addr", 32'(text_addr), 32'(a));
    if (reset)
      chk("font_addr_rst", 32'(font_addr), 32'h0);
    else if (!rst_m1 && hist >= 2)
      chk("font_addr", 32'(font_addr), 32'(fa_m2));
    chk("rgb", 32'(rgb), 32'(exp_o.rgb));
    chk("hsync_out", 32'(hsync_out), 32'(exp_o.hs));
    chk("vsync_out", 32'(vsync_out), 32'(exp_o.vs));
    chk("de_out", 32'(de_out), 32'(exp_o.de));
    fa_m2  = fa_m1;
    fa_m1  = fa_now;
    rst_m1 = reset;
    hist++;
  endtask

  task automatic drive(input int x, input int y, input logic vis, input logic hs, input logic vs);
    x_in = 16'(x); y_in = 16'(y);
    visible_in = vis; hsync_in = hs; vsync_in = vs;
    step();
  endtask

  // Cursor cell (2,3) pixel at glyph row 5, then flush and check its colour
  task automatic cur_pix(input logic [23:0] exp, input string name);
    drive(16, 53, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk(name, 32'(rgb), 32'(exp));
  endtask

  task automatic vs_edges(input int n);
    repeat (n) begin
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) tram[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) from[i] = 8'($urandom);
    tram[0]      = 16'h1F41;
    tram[482]    = 16'h1F41;   // cell (col 2, row 3)
    tram[7199]   = 16'h2A5C;
    from[12'h410] = 8'h80;
    from[12'h415] = 8'hFF;
    text_data = '0; font_data = '0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    x_in = '0; y_in = '0; hsync_in = 1'b0; vsync_in = 1'b0; visible_in = 1'b0;

    // Reset with arbitrary inputs
    reset = 1'b1;
    repeat (3) drive(int'($urandom_range(0, 1650)), int'($urandom_range(0, 750)),
                     1'($urandom), 1'($urandom), 1'($urandom));
    chk("reset_rgb", 32'(rgb), 32'h0);
    chk("reset_de", 32'(de_out), 32'h0);
    chk("reset_hs", 32'(hsync_out), 32'h0);
    chk("reset_vs", 32'(vsync_out), 32'h0);
    chk("reset_ta", 32'(text_addr), 32'h0);
    chk("reset_fa", 32'(font_addr), 32'h0);
    reset = 1'b0;

    // Latency and colour
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    chk("lat_ta", 32'(text_addr), 32'h0);
    drive(1, 0, 1'b1, 1'b0, 1'b0);
    drive(2, 0, 1'b1, 1'b0, 1'b0);
    chk("lat_fa", 32'(font_addr), 32'h410);
    drive(3, 0, 1'b1, 1'b0, 1'b0);
    drive(4, 0, 1'b1, 1'b0, 1'b0);
    chk("lat_rgb_fg", 32'(rgb), 32'hFFFFFF);
    drive(5, 0, 1'b1, 1'b0, 1'b0);
    chk("lat_rgb_bg", 32'(rgb), 32'h0000AA);

    // Address corner
    drive(1279, 719, 1'b1, 1'b0, 1'b0);
    chk("corner_ta", 32'(text_addr), 32'd7199);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk("corner_fa", 32'(font_addr), 32'h5CF);

    // Blanking and hsync pulse alignment
    for (int i = 0; i < 9; i++) begin
      drive(16, 53, 1'b0, (i < 3), 1'b0);
      if (i == 3) chk("hs_before", 32'(hsync_out), 32'h0);
      if (i == 4) begin
        chk("hs_rise", 32'(hsync_out), 32'h1);
        chk("blank_rgb", 32'(rgb), 32'h0);
        chk("blank_de", 32'(de_out), 32'h0);
      end
      if (i == 6) chk("hs_hold", 32'(hsync_out), 32'h1);
      if (i == 7) chk("hs_fall", 32'(hsync_out), 32'h0);
    end

    // Cursor blink
    reset = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cursor_en = 1'b1; cursor_col = 8'd2; cursor_row = 6'd3;
    cur_pix(24'h0000AA, "cursor_shown");
    vs_edges(29);
    drive(16, 53, 1'b1, 1'b0, 1'b1);   // 30th edge on the cursor pixel
    drive(16, 53, 1'b1, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk("cursor_pretoggle", 32'(rgb), 32'h0000AA);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    chk("cursor_posttoggle", 32'(rgb), 32'hFFFFFF);
    cur_pix(24'hFFFFFF, "cursor_hidden");
    vs_edges(30);
    cur_pix(24'h0000AA, "cursor_back");

    // Mid-frame reset: phase 0 with nonzero count beforehand
    vs_edges(35);
    cur_pix(24'hFFFFFF, "pre_reset_hidden");
    for (int i = 0; i < 6; i++) drive(8 * i, 53, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    drive(100, 200, 1'b1, 1'b1, 1'b1);
    chk("midrst_rgb", 32'(rgb), 32'h0);
    chk("midrst_de", 32'(de_out), 32'h0);
    chk("midrst_hs", 32'(hsync_out), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(16, 53, 1'b1, 1'b0, 1'b0);
      if (i == 3) chk("midrst_de_low", 32'(de_out), 32'h0);
      if (i == 4) begin
        chk("midrst_de_high", 32'(de_out), 32'h1);
        chk("midrst_phase1", 32'(rgb), 32'h0000AA);
      end
    end
    vs_edges(29);
    cur_pix(24'h0000AA, "midrst_cnt29");
    vs_edges(1);
    cur_pix(24'hFFFFFF, "midrst_cnt30");

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      int   x, y;
      logic vis, hs, vs;
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) begin
        x = int'($urandom_range(0, 65535));
        y = int'($urandom_range(0, 65535));
      end else begin
        x = int'($urandom_range(0, 1650));
        y = int'($urandom_range(0, 750));
      end
      vis = (x < 1280) && (y < 720) && ($urandom_range(0, 9) != 0);
      hs  = ($urandom_range(0, 7) == 0);
      vs  = ($urandom_range(0, 5) == 0) ? ~vsync_in : vsync_in;
      cursor_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        cursor_col = 8'(x >> 3);
        cursor_row = 6'(y >> 4);
      end else begin
        cursor_col = 8'($urandom_range(0, 159));
        cursor_row = 6'($urandom_range(0, 44));
      end
      drive(x, y, vis, hs, vs);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
